// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB definitions: HTRANS encodings and the arbiter state type.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package AHB_package;

    // HTRANS encodings as seen on each master channel.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    // SEQ and BUSY both mean "my burst is still running".
    function automatic logic htrans_continues(input logic [1:0] t);
        return (t == SEQ) || (t == BUSY);
    endfunction

    // NONSEQ and SEQ are the transfer types that produce a data phase.
    function automatic logic htrans_active(input logic [1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// Bundle between the master channels and one per-slave arbiter.
// Latency: none (wiring only).
// Backpressure: hready_in from the slave stalls every arbiter decision.
// Ports:
//   req / htrans_in / hready_in        : driven by the master side
//   sel_addr / sel_data / hgrant /
//   owner_valid                        : driven by the arbiter
interface ahb_slave_arbiter_if #(
    parameter int CHANNEL_NUM = 4
);
    logic [CHANNEL_NUM-1:0]      req;
    logic [CHANNEL_NUM-1:0][1:0] htrans_in;
    logic                        hready_in;
    logic [CHANNEL_NUM-1:0]      sel_addr;
    logic [CHANNEL_NUM-1:0]      sel_data;
    logic [CHANNEL_NUM-1:0]      hgrant;
    logic                        owner_valid;

    modport master (
        output req, htrans_in, hready_in,
        input  sel_addr, sel_data, hgrant, owner_valid
    );

    modport slave (
        input  req, htrans_in, hready_in,
        output sel_addr, sel_data, hgrant, owner_valid
    );
endinterface

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or above rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is used.
// Ports:
//   req        : request vector
//   rr_ptr     : highest-priority index
//   winner     : one-hot winner, zero when no request
//   winner_idx : binary index of winner, zero when no request
//   any_req    : at least one request bit set
module ahb_rr_picker #(
    parameter  int CHANNEL_NUM = 4,
    localparam int PTR_W       = $clog2(CHANNEL_NUM)
) (
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [CHANNEL_NUM-1:0] winner,
    output logic [PTR_W-1:0]       winner_idx,
    output logic                   any_req
);

    int w_idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            // Wrap explicitly so non-power-of-two channel counts work.
            w_idx = int'(rr_ptr) + k;
            if (w_idx >= CHANNEL_NUM) begin
                w_idx = w_idx - CHANNEL_NUM;
            end
            if (!any_req && req[w_idx]) begin
                any_req        = 1'b1;
                winner[w_idx]  = 1'b1;
                winner_idx     = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: burst-locked ownership, round-robin between bursts.
// Latency: grant one cycle after the sampling edge; sel_data one accepted transfer after sel_addr.
// Backpressure: hready_in = 0 freezes state, owner, rr_ptr and sel_data.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus (slave)   : req/htrans_in/hready_in in; sel_addr/sel_data/hgrant/owner_valid out
module ahb_slave_arbiter
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 4
) (
    input logic                HCLK,
    input logic                HRESETn,
    ahb_slave_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(CHANNEL_NUM);

    arb_state_e             r_state;
    arb_state_e             w_next_state;
    logic [PTR_W-1:0]       r_owner;
    logic [CHANNEL_NUM-1:0] r_owner_oh;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [CHANNEL_NUM-1:0] r_sel_data;

    logic [CHANNEL_NUM-1:0] w_winner;
    logic [PTR_W-1:0]       w_winner_idx;
    logic                   w_any_req;
    logic [PTR_W-1:0]       w_rr_next;
    logic [1:0]             w_owner_htrans;
    logic                   w_hold;
    logic                   w_rearb;
    logic [CHANNEL_NUM-1:0] w_sel_addr;

    ahb_rr_picker #(
        .CHANNEL_NUM (CHANNEL_NUM)
    ) u_picker (
        .req        (bus.req),
        .rr_ptr     (r_rr_ptr),
        .winner     (w_winner),
        .winner_idx (w_winner_idx),
        .any_req    (w_any_req)
    );

    // Only the owner's lane is indexed, so X on other channels cannot
    // leak into the hold decision.
    assign w_owner_htrans = bus.htrans_in[r_owner];
    assign w_hold  = (r_state == ARB_OWN) && bus.req[r_owner]
                     && htrans_continues(w_owner_htrans);
    assign w_rearb = bus.hready_in && !w_hold;

    // Pointer moves just past the new owner, making it lowest priority next time.
    assign w_rr_next = (w_winner_idx == PTR_W'(CHANNEL_NUM - 1))
                       ? '0 : w_winner_idx + 1'b1;

    // State register, plus the owner/pointer/data-phase registers that
    // advance on the same accepted edges.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ARB_IDLE;
            r_owner    <= '0;
            r_owner_oh <= '0;
            r_rr_ptr   <= '0;
            r_sel_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_rearb && w_any_req) begin
                r_owner    <= w_winner_idx;
                r_owner_oh <= w_winner;
                r_rr_ptr   <= w_rr_next;
            end
            if (bus.hready_in) begin
                r_sel_data <= (r_state == ARB_OWN && htrans_active(w_owner_htrans))
                              ? w_sel_addr : '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        if (bus.hready_in) begin
            if (w_hold) begin
                w_next_state = ARB_OWN;
            end else if (w_any_req) begin
                w_next_state = ARB_OWN;
            end else begin
                w_next_state = ARB_IDLE;
            end
        end
    end

    // Output decode from registers only: no req-to-sel_addr path.
    always_comb begin
        w_sel_addr = '0;
        if (r_state == ARB_OWN) begin
            w_sel_addr = r_owner_oh;
        end
    end

    assign bus.sel_addr    = w_sel_addr;
    assign bus.hgrant      = w_sel_addr;
    assign bus.sel_data    = r_sel_data;
    assign bus.owner_valid = (r_state == ARB_OWN);

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed self-checking bench for ahb_slave_arbiter (4 channels).
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: hready_in driven low for the wait-state steps.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic HCLK;
    logic HRESETn;
    int   errors;
    int   checks;

    ahb_slave_arbiter_if #(.CHANNEL_NUM(4)) bus ();

    ahb_slave_arbiter #(.CHANNEL_NUM(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_sel(input string tag, input logic [3:0] exp_addr, input logic [3:0] exp_data);
        chk({tag, ".sel_addr"}, bus.sel_addr, exp_addr);
        chk({tag, ".hgrant"},   bus.hgrant,   exp_addr);
        chk({tag, ".sel_data"}, bus.sel_data, exp_data);
        chk({tag, ".owner_valid"}, {3'b000, bus.owner_valid}, {3'b000, (exp_addr != 4'b0000)});
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        HRESETn       = 1'b0;
        bus.req       = 4'b1111;
        bus.htrans_in = {HT_NONSEQ, HT_NONSEQ, HT_NONSEQ, HT_NONSEQ};
        bus.hready_in = 1'b1;

        // Reset held with every master requesting.
        tick();
        tick();
        chk_sel("reset_hold", 4'b0000, 4'b0000);

        // Release with hready low: the first edge must not grant.
        HRESETn       = 1'b1;
        bus.hready_in = 1'b0;
        tick();
        chk_sel("release_wait", 4'b0000, 4'b0000);
        bus.hready_in = 1'b1;
        tick();
        chk_sel("release_grant", 4'b0001, 4'b0000);

        // Round robin with single NONSEQ transfers from everyone: 1,2,3,0.
        tick();
        chk_sel("rr_1", 4'b0010, 4'b0001);
        tick();
        chk_sel("rr_2", 4'b0100, 4'b0010);
        tick();
        chk_sel("rr_3", 4'b1000, 4'b0100);
        tick();
        chk_sel("rr_0", 4'b0001, 4'b1000);

        // Only master 2 asks: rr_ptr=1 picks 2, pointer moves to 3.
        bus.req = 4'b0100;
        tick();
        chk_sel("burst_grant", 4'b0100, 4'b0001);

        // Burst continues with SEQ while master 1 also requests.
        bus.req       = 4'b0110;
        bus.htrans_in = {HT_NONSEQ, HT_SEQ, HT_NONSEQ, HT_NONSEQ};
        tick();
        chk_sel("burst_seq1", 4'b0100, 4'b0100);
        tick();
        chk_sel("burst_seq2", 4'b0100, 4'b0100);

        // Wait states: other requests and even the owner lane wiggle.
        bus.hready_in = 1'b0;
        bus.req       = 4'b1011;
        tick();
        chk_sel("wait_1", 4'b0100, 4'b0100);
        bus.req       = 4'b0001;
        bus.htrans_in = {HT_NONSEQ, HT_IDLE, HT_NONSEQ, HT_NONSEQ};
        tick();
        chk_sel("wait_2", 4'b0100, 4'b0100);
        bus.req = 4'b1111;
        tick();
        chk_sel("wait_3", 4'b0100, 4'b0100);

        bus.hready_in = 1'b1;
        bus.req       = 4'b0110;
        bus.htrans_in = {HT_NONSEQ, HT_SEQ, HT_NONSEQ, HT_NONSEQ};
        tick();
        chk_sel("burst_seq3", 4'b0100, 4'b0100);

        // Master 2 issues IDLE: rr_ptr still 3, so search 3,0,1 gives 1.
        bus.htrans_in = {HT_NONSEQ, HT_IDLE, HT_NONSEQ, HT_NONSEQ};
        tick();
        chk_sel("handover", 4'b0010, 4'b0000);

        // Master 3 alone, back-to-back NONSEQ singles.
        bus.req = 4'b1000;
        tick();
        chk_sel("sole_grant", 4'b1000, 4'b0010);
        tick();
        chk_sel("sole_b2b_1", 4'b1000, 4'b1000);
        tick();
        chk_sel("sole_b2b_2", 4'b1000, 4'b1000);

        // Everyone goes quiet.
        bus.req       = 4'b0000;
        bus.htrans_in = {HT_IDLE, HT_IDLE, HT_IDLE, HT_IDLE};
        tick();
        chk_sel("to_idle", 4'b0000, 4'b0000);
        tick();
        chk_sel("stay_idle", 4'b0000, 4'b0000);

        // Burst from master 1 (rr_ptr=0 so 1 wins), then async reset mid-burst.
        bus.req       = 4'b0010;
        bus.htrans_in = {HT_IDLE, HT_IDLE, HT_SEQ, HT_IDLE};
        tick();
        chk_sel("pre_rst_grant", 4'b0010, 4'b0000);
        tick();
        chk_sel("pre_rst_seq", 4'b0010, 4'b0010);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_sel("async_rst", 4'b0000, 4'b0000);

        // After release the pointer is back at 0.
        tick();
        HRESETn       = 1'b1;
        bus.req       = 4'b1111;
        bus.htrans_in = {HT_NONSEQ, HT_NONSEQ, HT_NONSEQ, HT_NONSEQ};
        tick();
        chk_sel("post_rst_grant", 4'b0001, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave arbiter of the AHB interconnect. Sits directly upstream of the slave-side payload mux: it watches every master channel that is addressing this slave and produces the one-hot `sel` that steers the winning master's address/control payload onto the slave. It also produces a registered data-phase select for the response and write-data return path. Ownership is held for the whole of an AHB burst and arbitrated round-robin between bursts.

## Interface
- `CHANNEL_NUM`, default 4: number of master channels; must be ≥2.
- `HCLK`, input, 1: system clock; all state changes on the rising edge.
- `HRESETn`, input, 1: asynchronous, active-low reset.
- `req`, input, `CHANNEL_NUM`: bit i = master i's decoder selects this slave in the current address phase.
- `htrans_in`, input, `[CHANNEL_NUM-1:0][1:0]`: HTRANS of each master.
- `hready_in`, input, 1: slave HREADYOUT; 1 = the current transfer completes this cycle.
- `sel_addr`, output, `CHANNEL_NUM`: one-hot address-phase select, all-zero when no owner; drives the payload mux `sel`.
- `sel_data`, output, `CHANNEL_NUM`: one-hot data-phase select, `sel_addr` delayed by one accepted transfer.
- `hgrant`, output, `CHANNEL_NUM`: equals `sel_addr`, routed back to the masters.
- `owner_valid`, output, 1: 1 in state OWN.

## Operation
- State machine with two states:
  - IDLE: no owner, `sel_addr = 0`, and the mux presents all-zero, which is HTRANS IDLE.
  - OWN: registered `owner` index, `sel_addr = 1 << owner`.
- Round-robin pointer `rr_ptr` (log2 `CHANNEL_NUM` bits). Winner = first set `req` bit searching upward from `rr_ptr`, wrapping modulo `CHANNEL_NUM`.
- Evaluation happens only on edges where `hready_in = 1`. With `hready_in = 0`, state, `owner`, `rr_ptr` and `sel_data` all hold.
- From IDLE:
  - any `req` set → OWN, `owner` = winner, `rr_ptr` = winner+1 (wrapping).
  - no `req` → stay IDLE.
- From OWN, the owner keeps the slave ("hold") when `req[owner] = 1` and `htrans_in[owner]` is SEQ or BUSY.
- From OWN, otherwise (owner issues NONSEQ/IDLE, or drops `req`):
  - Re-arbitrate with `rr_ptr`, which already points past the owner, so the owner has the lowest priority.
  - A winner (possibly the same owner if it is the only requester) → OWN with the new `owner` and `rr_ptr` update.
  - No requester → IDLE.
- `sel_data` register: on an edge with `hready_in = 1`, loads `sel_addr` if the owner's `htrans_in` is NONSEQ/SEQ; otherwise loads 0.
- A `req` bit set without a grant is ignored; no request queueing, because masters hold `req` until granted.
- X on `req`/`htrans_in` of non-owners must not affect the hold decision.

## Timing
- Reset (asynchronous assert, synchronous-to-`HCLK` release): state IDLE, `owner` = 0, `rr_ptr` = 0, `sel_addr`/`hgrant`/`sel_data` = 0, `owner_valid` = 0.
- Grant latency: `req` seen at edge k (with `hready_in = 1`) → `sel_addr` valid after edge k, i.e. 1 cycle.
- `sel_addr` is decoded from registers only; there is no combinational path from `req` to `sel_addr`.
- `sel_data` lags `sel_addr` by exactly one accepted transfer; wait states stretch both.
- Handover: the last beat of burst A and the first NONSEQ of master B are separated by one address-phase cycle. In that cycle the mux presents IDLE, because `req` is sampled at the edge that ends A's last address phase.
- Reset asserted mid-burst: immediate return to IDLE with all selects 0; no beat is completed on the slave side.

## Structure
- `AHB_package` holds:
  - HTRANS constants IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11;
  - the `arb_state_e` enum {ARB_IDLE, ARB_OWN}.
- Sub-module `ahb_rr_picker` (combinational): inputs `req` and `rr_ptr`; outputs one-hot `winner`, `winner_idx` and `any_req`. It is reusable by the master-side arbiters.
- Top level holds the FSM, the `owner`/`rr_ptr` registers and the `sel_data` register.

## Test plan
- Reset: hold `HRESETn = 0` with `req = 4'b1111` → all outputs 0. Release → `sel_addr = 4'b0001` one cycle after the first edge with `hready_in = 1`.
- Burst hold: master 2 issues NONSEQ then 3×SEQ with `req = 4'b0110` throughout → `sel_addr = 4'b0100` for all 4 beats. Master 1 is granted (`4'b0010`) only after master 2 issues IDLE.
- Wait states: `hready_in = 0` for 3 cycles mid-burst while other `req` bits toggle → `sel_addr`, `sel_data` and `rr_ptr` unchanged.
- Round-robin fairness: all four masters request continuously with single NONSEQ transfers → grant order 0,1,2,3,0.
- Sole requester: master 3 issues back-to-back NONSEQ singles alone → `sel_addr` stays `4'b1000` with no IDLE gap. `sel_data` follows one accepted transfer later.
- Async reset mid-burst: assert `HRESETn` low between edges → outputs 0 immediately without waiting for an edge. After release, arbitration restarts from `rr_ptr = 0`.
